// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and default widths for the instruction fetch stage
package fetch_pkg;
    localparam int FETCH_ADDR_W = 11;
    localparam int FETCH_DATA_W = 32;
    typedef enum logic {IDLE, RUN} fetch_state_t;
    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO with flush, push/pop at any occupancy
module fetch_fifo import fetch_pkg::*; #(
    parameter int DEPTH = 2,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           push,
    input  entry_t                         wdata,
    input  logic                           pop,
    output entry_t                         rdata,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    entry_t mem [DEPTH];
    logic [AW-1:0] wp, rp;
    assign rdata = mem[rp];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) mem[wp] <= wdata;
            wp <= flush ? '0 : wp + AW'(push);
            rp <= flush ? '0 : rp + AW'(pop);
            count <= flush ? '0 : count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: prefetching instruction fetch stage with load/redirect and valid/ready output
module instr_fetch_unit import fetch_pkg::*; #(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int DATA_W = FETCH_DATA_W,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic              load_pc,
    input  logic              redirect_en,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc
);
    localparam int CW = $clog2(DEPTH + 1);
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;
    fetch_state_t state, state_nxt;
    logic [ADDR_W-1:0] fetch_pc, pc_tag;
    logic [CW-1:0] count;
    logic inflight, flush, push, pop, issue;
    entry_t head;
    always_ff @(posedge clk) begin
        state <= !rst_n ? IDLE : state_nxt;
    end
    always_comb begin
        state_nxt = load_pc ? RUN : state;
    end
    always_comb begin
        flush = load_pc || (state == RUN && redirect_en);
        push = inflight && !flush;
        issue = state == RUN && !load_pc && !redirect_en &&
                (int'(count) + int'(inflight) - int'(pop) < DEPTH);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc <= '0;
            pc_tag <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) pc_tag <= fetch_pc;
            fetch_pc <= load_pc ? start_pc :
                        (state == RUN && redirect_en) ? redirect_pc :
                        issue ? fetch_pc + ADDR_W'(1) : fetch_pc;
        end
    end
    fetch_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .push(push),
        .wdata('{pc: pc_tag, instr: mem_rdata}),
        .pop(pop),
        .rdata(head),
        .count(count)
    );
    assign instr_valid = count != '0;
    assign pop = instr_valid && instr_ready;
    assign mem_rd = issue;
    assign mem_addr = fetch_pc;
    assign instr = head.instr;
    assign instr_pc = head.pc;
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage placed directly upstream of the multi-cycle core in `integrated_cpu`. It reads 32-bit instruction words from the instruction port of the dual-port memory and buffers them in a small prefetch FIFO. It hands them to decode through a valid/ready handshake. It also accepts the reset-time `start_pc` load and branch redirects from the datapath.

## Interface
- `ADDR_W`, default 11: word address width, matching `start_pc`.
- `DATA_W`, default 32: instruction width.
- `DEPTH`, default 2: prefetch FIFO entries. Power of two, ≥2.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start_pc`  in  ADDR_W  initial fetch word address.
- `load_pc`  in  1  one-cycle pulse; latch `start_pc` and begin fetching.
- `redirect_en`  in  1  one-cycle pulse; branch taken, flush and refetch.
- `redirect_pc`  in  ADDR_W  branch target word address.
- `mem_rd`  out  1  read request to the instruction memory port.
- `mem_addr`  out  ADDR_W  read address. Valid when `mem_rd`=1.
- `mem_rdata`  in  DATA_W  read data, valid exactly one cycle after the request edge (synchronous RAM).
- `instr_valid`  out  1  `instr`/`instr_pc` hold a fetched word.
- `instr_ready`  in  1  consumer accepts the word this cycle.
- `instr`  out  DATA_W  instruction word at the FIFO head.
- `instr_pc`  out  ADDR_W  word address of `instr`.

## Operation
- States: IDLE (after reset) and RUN.
  - IDLE → RUN on `load_pc`.
  - RUN stays in RUN. Only reset returns the block to IDLE.
- `load_pc` behaviour:
  - In IDLE or RUN: fetch_pc ← `start_pc`.
  - FIFO flushed; any in-flight response discarded.
- `redirect_en` behaviour:
  - In RUN: fetch_pc ← `redirect_pc`.
  - FIFO flushed; the in-flight response arriving next cycle is discarded.
  - Ignored in IDLE.
- Priority when both pulse in the same cycle: `load_pc` wins and `redirect_en` is ignored.
- Issue rule: `mem_rd` = RUN && !load_pc && !redirect_en && (count + inflight − pop) < DEPTH.
  - pop = `instr_valid` && `instr_ready`.
  - `mem_addr` = fetch_pc. Both are combinational from registered state.
  - On issue: fetch_pc ← fetch_pc + 1, mod 2^ADDR_W (0x7FF → 0x000). The address tag travels with the request.
- Response: in the cycle after an issue, `mem_rdata` is pushed with its tag unless it is killed by a flush.
- Handshake:
  - `instr_valid` = FIFO non-empty.
  - While `instr_valid`=1 and `instr_ready`=0, `instr`/`instr_pc` hold stable.
  - A word is never dropped or duplicated except by a flush.
- A pop in the same cycle as a flush completes: that word counts as consumed.
- Push and pop in the same cycle are allowed at any occupancy, including full.
- Invariant: count + inflight ≤ DEPTH at all times, so no overflow.
- Reset values:
  - Outputs: `instr_valid`=0, `mem_rd`=0, `mem_addr`=0, `instr`=0, `instr_pc`=0.
  - Internal: fetch_pc=0, FIFO empty, inflight=0, state IDLE.

## Timing
- Load/redirect edge E0 → `mem_rd` high in the cycle after E0.
- RAM samples at E1; the word is pushed at E2; `instr_valid`=1 after E2. Load-to-valid latency is 2 cycles.
- With DEPTH=2 and `instr_ready` held high: one instruction per cycle after the initial 2-cycle latency.
- Under backpressure: `mem_rd` falls once count + inflight = DEPTH, and resumes in the same cycle as the first pop.
- Reset mid-operation: at the next edge with `rst_n`=0, all state returns to reset values. A response arriving after reset is ignored.

## Structure
- Package `fetch_pkg` holds:
  - `fetch_state_t` (IDLE, RUN).
  - A `fetch_entry_t` struct {pc, instr}.
  - Default ADDR_W/DATA_W constants, shared with `integrated_cpu`.
- Sub-module `fetch_fifo`: synchronous FIFO of `fetch_entry_t` with a `flush` input, push/pop, and a count output.
- The top level holds the FSM, fetch_pc, the inflight/kill flag, and the issue logic.

## Test plan
- Reset, memory word i = 0x100+i, `start_pc`=0, `load_pc` pulse, `instr_ready`=1:
  - `instr_valid` after 2 edges, `instr`=0x100, `instr_pc`=0.
  - Then pc 1, 2, 3 on consecutive cycles.
- Hold `instr_ready`=0 for 5 cycles after the first valid:
  - `instr`=0x100 stays stable.
  - `mem_rd` low once 2 words are held.
  - On release, pcs 0, 1, 2 appear in order, with no gap beyond the refill.
- `redirect_en`, `redirect_pc`=0x40, while a request to pc 5 is in flight:
  - The pc 5 word is never presented.
  - The next valid word is `instr_pc`=0x40, 2 cycles after the redirect edge.
- `start_pc`=0x7FE: presented pcs are 0x7FE, 0x7FF, 0x000, 0x001.
- `rst_n`=0 for one edge mid-stream:
  - Next cycle: `instr_valid`=0, `mem_rd`=0, state IDLE.
  - No `mem_rd` until the next `load_pc`.
- `load_pc` (`start_pc`=0x10) and `redirect_en` (`redirect_pc`=0x20) in the same cycle: first valid `instr_pc`=0x10.
